prbs_checker: RTL and testbench
===============================

# prbs_checker

Receive-side checker for the 8-bit LFSR pseudo-random stream, with feedback x^8+x^7+1, reset seed 8'h01, sequence 01,02,04,08,10,20,40,81,03,06,…. The block consumes one generator word per enabled cycle and self-synchronises by seeding its own predictor from the incoming data. After lock it flywheels on its own prediction and counts mismatching words. It sits at the far end of any link carrying the generator output, for link test and bit-error counting.

## Interface
- WIDTH, 8: word width; the tap function is fixed for 8.
- SYNC_COUNT, 4: consecutive matching words, after the seed, required to lock.
- LOSS_COUNT, 3: consecutive mismatching words in LOCKED that drop lock.
- ERR_W, 16: error counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  data_in valid this cycle.
- data_in  in  WIDTH  received generator word.
- clr_err  in  1  synchronous clear of err_count.
- locked  out  1  checker in LOCKED.
- err_pulse  out  1  one-cycle flag: enabled word mismatched while LOCKED.
- err_count  out  ERR_W  saturating count of mismatched words while LOCKED.

## Operation
- Next-state function: next(s) = {s[6:0], s[6]^s[7]}. Expected word register `exp` holds the prediction for the next enabled word.
- States:
  - HUNT: no seed held.
  - SYNC: seeded, counting matches.
  - LOCKED.
- HUNT, en=1:
  - data_in==0 (the lockup word): ignored, stay in HUNT.
  - Otherwise: exp<=next(data_in), match_cnt<=0, go to SYNC.
- SYNC, en=1:
  - data_in==exp: exp<=next(exp), match_cnt++. When match_cnt reaches SYNC_COUNT, go to LOCKED and clear miss_cnt.
  - Mismatch, data_in≠0: reseed with exp<=next(data_in), match_cnt<=0, stay in SYNC.
  - Mismatch, data_in==0: go to HUNT.
  - No errors are counted in SYNC.
- LOCKED, en=1: exp<=next(exp) always (flywheel, never reseeded from data).
  - Match: miss_cnt<=0.
  - Mismatch: err_pulse=1, err_count+1 (saturates at all-ones), miss_cnt++.
  - When miss_cnt reaches LOSS_COUNT, go to HUNT. That final mismatch is still counted.
- en=0: no state, counter or exp change; err_pulse=0.
- clr_err: err_count<=0. It takes priority over a simultaneous increment.
- Reset values:
  - Outputs: locked=0, err_pulse=0, err_count=0.
  - Internal: state=HUNT, exp=0, match_cnt=0, miss_cnt=0.
- rst mid-operation returns to HUNT regardless of state. Any seed or lock is lost.

## Timing
- All outputs are registered and update on the edge that samples the enabled word.
- Lock latency: 1 seed word + SYNC_COUNT matching words. With the default of 4, locked rises on the edge sampling the 5th consecutive valid word.
- err_pulse is high for exactly the cycle after the edge sampling the erroneous word.
- err_count reflects that word in the same cycle.
- Unlock: locked falls on the edge sampling the LOSS_COUNT-th consecutive mismatch. err_pulse is also high for that word.
- Gaps in en do not break sync; only enabled words are evaluated.
- Throughput is one word per cycle, with no back-pressure.

## Structure
- Package prbs_pkg holds:
  - state enum (HUNT, SYNC, LOCKED).
  - PRBS_SEED = 8'h01.
  - function lfsr_next(s), shared with the generator so both ends use one polynomial definition.
- Counter widths are $clog2(SYNC_COUNT+1) and $clog2(LOSS_COUNT+1).
- No sub-module: one FSM plus the exp register and three counters. The err_count saturating counter may be a local always_ff.

## Test plan
- Clean stream: reset, then feed 01,02,04,08,10 with en=1 each cycle.
  - locked=1 after the 10 word; err_count=0.
  - Continue 20,40,81,03: locked stays 1, no err_pulse.
- Single error: once locked and expecting 06, inject 07, then resume 0C,18.
  - Required: one err_pulse, err_count=1, locked stays 1.
  - Next words match, because the flywheel prediction is unaffected by the bad word.
- Loss of lock: once locked, feed 3 words that all mismatch.
  - Required: err_count=3, locked falls on the 3rd.
  - Then feed a fresh sequence from 81: relock after 5 words.
- Hunt and zero words: from reset feed 00,00,20,40,81,03,06.
  - The 00 words are ignored; seed is 20.
  - Required: locked=1 after 06.
  - A 00 arriving mid-SYNC returns the checker to HUNT.
- en gaps and clr_err:
  - Locked stream with en toggling 1,0,0,1: still no errors.
  - err_count preset to 0xFFFF with another error: stays 0xFFFF.
  - clr_err in the same cycle as an error: count=0.
- Reset mid-lock: rst for 1 cycle while locked.
  - Next cycle: locked=0, err_count=0, err_pulse=0, state HUNT.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared definitions for the x^8+x^7+1 PRBS generator/checker pair.
// Both ends call lfsr_next so the polynomial is defined in one place only.
package prbs_pkg;

    localparam int            PRBS_W    = 8;
    localparam logic [7:0]    PRBS_SEED = 8'h01;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [PRBS_W-1:0] lfsr_next(input logic [PRBS_W-1:0] s);
        return {s[6:0], s[6] ^ s[7]};
    endfunction

endpackage

// File: rtl/prbs_checker.sv
// Self-synchronising receive checker for the 8-bit PRBS stream: seeds from data,
// locks after a run of matches, then flywheels and counts mismatched words.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SYNC_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int MATCH_W = $clog2(SYNC_COUNT + 1);
    localparam int MISS_W  = $clog2(LOSS_COUNT + 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(SYNC_COUNT - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_COUNT - 1);

    state_t             state;
    logic [WIDTH-1:0]   exp;
    logic [MATCH_W-1:0] match_cnt;
    logic [MISS_W-1:0]  miss_cnt;
    logic               word_ok;
    logic               data_zero;
    logic               err_hit;

    assign word_ok   = (data_in == exp);
    assign data_zero = (data_in == '0);
    assign err_hit   = en && (state == LOCKED) && !word_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            exp       <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (en) begin
                case (state)
                    HUNT: begin
                        // The all-zero word is the LFSR lockup state and can never seed.
                        if (!data_zero) begin
                            exp       <= lfsr_next(data_in);
                            match_cnt <= '0;
                            state     <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (word_ok) begin
                            exp       <= lfsr_next(exp);
                            match_cnt <= match_cnt + 1'b1;
                            if (match_cnt == MATCH_LAST) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end else if (!data_zero) begin
                            exp       <= lfsr_next(data_in);
                            match_cnt <= '0;
                        end else begin
                            state <= HUNT;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: prediction never follows the received data once locked.
                        exp <= lfsr_next(exp);
                        if (word_ok) begin
                            miss_cnt <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                            miss_cnt  <= miss_cnt + 1'b1;
                            if (miss_cnt == MISS_LAST) begin
                                state  <= HUNT;
                                locked <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_err) begin
            err_count <= '0;
        end else if (err_hit && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker; a second instance with a 2-bit error counter
// shares the stimulus so counter saturation is reached in a few words.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  data_in;
    logic        clr_err;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic        sat_locked;
    logic        sat_err_pulse;
    logic [1:0]  sat_err_count;

    int total  = 0;
    int passed = 0;

    prbs_checker #(.WIDTH(8), .SYNC_COUNT(4), .LOSS_COUNT(3), .ERR_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .data_in   (data_in),
        .clr_err   (clr_err),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    prbs_checker #(.WIDTH(8), .SYNC_COUNT(4), .LOSS_COUNT(3), .ERR_W(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .data_in   (data_in),
        .clr_err   (clr_err),
        .locked    (sat_locked),
        .err_pulse (sat_err_pulse),
        .err_count (sat_err_count)
    );

    always #5 clk = ~clk;

    task automatic step(input logic e, input logic [7:0] d, input logic c);
        en      = e;
        data_in = d;
        clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total = total + 1;
        assert (obs === expv) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic feed(input logic [7:0] d);
        step(1'b1, d, 1'b0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; data_in = 8'h00; clr_err = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_pulse", 32'(err_pulse), 32'd0);
        chk("reset_count", 32'(err_count), 32'd0);
        rst = 1'b0;

        // Clean stream: lock on the 5th word.
        feed(8'h01); feed(8'h02); feed(8'h04); feed(8'h08);
        chk("clean_not_yet_locked", 32'(locked), 32'd0);
        feed(8'h10);
        chk("clean_locked", 32'(locked), 32'd1);
        chk("clean_count", 32'(err_count), 32'd0);
        feed(8'h20); feed(8'h40); feed(8'h81);
        chk("clean_pulse_81", 32'(err_pulse), 32'd0);
        feed(8'h03);
        chk("clean_still_locked", 32'(locked), 32'd1);
        chk("clean_pulse_03", 32'(err_pulse), 32'd0);

        // Single error: expecting 06, send 07, then 0C,18 must match.
        feed(8'h07);
        chk("single_pulse", 32'(err_pulse), 32'd1);
        chk("single_count", 32'(err_count), 32'd1);
        chk("single_locked", 32'(locked), 32'd1);
        feed(8'h0C);
        chk("single_resume_pulse", 32'(err_pulse), 32'd0);
        chk("single_resume_count", 32'(err_count), 32'd1);
        feed(8'h18);
        chk("single_resume2_pulse", 32'(err_pulse), 32'd0);

        // clr_err alone with en low.
        step(1'b0, 8'h00, 1'b1);
        chk("clr_count", 32'(err_count), 32'd0);

        // Loss of lock: expecting 30, 60, C1; send three bad words.
        feed(8'h00);
        chk("loss1_locked", 32'(locked), 32'd1);
        feed(8'h00);
        chk("loss2_count", 32'(err_count), 32'd2);
        feed(8'h00);
        chk("loss3_locked", 32'(locked), 32'd0);
        chk("loss3_pulse", 32'(err_pulse), 32'd1);
        chk("loss3_count", 32'(err_count), 32'd3);

        // Relock from 81.
        feed(8'h81); feed(8'h03); feed(8'h06); feed(8'h0C);
        chk("relock_not_yet", 32'(locked), 32'd0);
        feed(8'h18);
        chk("relock_locked", 32'(locked), 32'd1);

        // en gaps: 30, gap, gap, 60; garbage on data while en is low.
        feed(8'h30);
        step(1'b0, 8'h55, 1'b0);
        chk("gap_pulse", 32'(err_pulse), 32'd0);
        step(1'b0, 8'hAA, 1'b0);
        feed(8'h60);
        chk("gap_resume_pulse", 32'(err_pulse), 32'd0);
        chk("gap_resume_count", 32'(err_count), 32'd3);
        chk("gap_resume_locked", 32'(locked), 32'd1);

        // Saturation: the 2-bit instance is at 3 and must hold there.
        chk("sat_before", 32'(sat_err_count), 32'd3);
        feed(8'h00);                          // expected C1
        chk("sat_main_count", 32'(err_count), 32'd4);
        chk("sat_held", 32'(sat_err_count), 32'd3);
        chk("sat_pulse", 32'(sat_err_pulse), 32'd1);
        feed(8'h82);

        // clr_err wins over a simultaneous error (expected 05).
        step(1'b1, 8'h00, 1'b1);
        chk("clr_vs_err_pulse", 32'(err_pulse), 32'd1);
        chk("clr_vs_err_count", 32'(err_count), 32'd0);
        chk("clr_vs_err_sat", 32'(sat_err_count), 32'd0);
        feed(8'h0A);
        chk("after_clr_count", 32'(err_count), 32'd0);

        // Reset mid-lock with an error word presented on the same edge.
        feed(8'h00);                          // expected 14
        chk("prereset_count", 32'(err_count), 32'd1);
        rst = 1'b1;
        feed(8'h00);
        rst = 1'b0;
        chk("midrst_locked", 32'(locked), 32'd0);
        chk("midrst_count", 32'(err_count), 32'd0);
        chk("midrst_pulse", 32'(err_pulse), 32'd0);

        // Hunt: zero words ignored, seed is 20.
        feed(8'h00); feed(8'h00);
        feed(8'h20); feed(8'h40); feed(8'h81); feed(8'h03);
        chk("hunt_not_yet", 32'(locked), 32'd0);
        feed(8'h06);
        chk("hunt_locked", 32'(locked), 32'd1);

        // A 00 in SYNC returns to HUNT: 08 then re-seeds and needs four more matches.
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        feed(8'h01); feed(8'h02); feed(8'h04); feed(8'h00);
        chk("sync_zero_count", 32'(err_count), 32'd0);
        feed(8'h08); feed(8'h10); feed(8'h20); feed(8'h40);
        chk("sync_zero_not_locked", 32'(locked), 32'd0);
        feed(8'h81);
        chk("sync_zero_relocked", 32'(locked), 32'd1);

        // Mismatches in SYNC are never counted.
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        feed(8'h01); feed(8'h55); feed(8'h33);
        chk("sync_mismatch_pulse", 32'(err_pulse), 32'd0);
        chk("sync_mismatch_count", 32'(err_count), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
